// File: rtl/wb_timer.sv
// Wishbone classic timer: prescaler, 32-bit down-counter with optional
// auto-reload, and a write-1-to-clear expiry flag driving a level interrupt.
module wb_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PRESC  = 3'd1;
    localparam logic [2:0] A_LOAD   = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic                  en_q, reload_q, irq_en_q, exp_q;
    logic [PRESCALE_W-1:0] prescale_q, pcnt_q;
    logic [31:0]           load_q, count_q;

    logic                  en_d, reload_d, irq_en_d, exp_d;
    logic [PRESCALE_W-1:0] prescale_d, pcnt_d;
    logic [31:0]           load_d, count_d;
    logic [31:0]           presc_ext, presc_m, rdata;

    logic       req, wr, tick, expire;
    logic [2:0] idx;

    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr     = req & wb_we_i;
    assign idx    = wb_adr_i[4:2];
    assign tick   = en_q && (pcnt_q == prescale_q);
    assign expire = tick && (count_q == 32'd0);
    assign irq_o  = exp_q & irq_en_q;

    always_comb begin
        presc_ext = '0;
        presc_ext[PRESCALE_W-1:0] = prescale_q;
    end

    assign presc_m    = merge(presc_ext, wb_dat_i, wb_sel_i);
    assign prescale_d = (wr && idx == A_PRESC) ?
                        presc_m[PRESCALE_W-1:0] : prescale_q;
    assign load_d     = (wr && idx == A_LOAD) ?
                        merge(load_q, wb_dat_i, wb_sel_i) : load_q;

    // A one-shot expiry stops the timer, but a CTRL write in the same cycle wins.
    always_comb begin
        en_d     = en_q;
        reload_d = reload_q;
        irq_en_d = irq_en_q;
        if (expire && !reload_q) en_d = 1'b0;
        if (wr && idx == A_CTRL && wb_sel_i[0]) begin
            en_d     = wb_dat_i[0];
            reload_d = wb_dat_i[1];
            irq_en_d = wb_dat_i[2];
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr && idx == A_COUNT) begin
            count_d = merge(count_q, wb_dat_i, wb_sel_i);
        end else if (tick) begin
            if (count_q != 32'd0) count_d = count_q - 32'd1;
            else if (reload_q)    count_d = load_q;
        end
    end

    // pcnt wraps naturally when PRESCALE is lowered below it.
    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (!en_q || (wr && idx == A_COUNT) || tick) pcnt_d = '0;
    end

    always_comb begin
        exp_d = exp_q;
        if (wr && idx == A_STATUS && wb_sel_i[0] && wb_dat_i[0]) exp_d = 1'b0;
        if (expire) exp_d = 1'b1;
    end

    always_comb begin
        rdata = 32'd0;
        case (idx)
            A_CTRL:   rdata = {29'd0, irq_en_q, reload_q, en_q};
            A_PRESC:  rdata = presc_ext;
            A_LOAD:   rdata = load_q;
            A_COUNT:  rdata = count_q;
            A_STATUS: rdata = {31'd0, exp_q};
            default:  rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q       <= 1'b0;
            reload_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            exp_q      <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 32'd0;
        end else begin
            en_q       <= en_d;
            reload_q   <= reload_d;
            irq_en_q   <= irq_en_d;
            exp_q      <= exp_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            load_q     <= load_d;
            count_q    <= count_d;
            wb_ack_o   <= req;
            if (req) wb_dat_o <= rdata;
        end
    end

    logic unused;
    assign unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], presc_m};

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: register access, periodic, prescaled,
// one-shot, byte-lane and collision behaviour, plus asynchronous reset.
module tb_wb_timer;

    localparam logic [31:0] CTRL   = 32'h00;
    localparam logic [31:0] PRESC  = 32'h04;
    localparam logic [31:0] LOAD   = 32'h08;
    localparam logic [31:0] COUNT  = 32'h0C;
    localparam logic [31:0] STATUS = 32'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdat;
    logic        ack;
    logic        irq;

    int checks = 0;
    int errors = 0;

    wb_timer #(.PRESCALE_W(16)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_dat_o (rdat),
        .wb_ack_o (ack),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic w,
                       output logic [31:0] q);
        bit got;
        got = 0;
        q = '0;
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1;
                q = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bus_ack adr=%h: no ack within 4 clocks, ack required", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s = 4'hF);
        logic [31:0] q;
        bus(a, d, s, 1'b1, q);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        bus(a, 32'd0, 4'h0, 1'b0, q);
    endtask

    task automatic stop_timer();
        wr(CTRL, 32'd0);
        wr(STATUS, 32'd1);
    endtask

    task automatic test_reset();
        logic [31:0] q;
        #20;
        checks++;
        if (ack !== 1'b0 || irq !== 1'b0 || rdat !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b irq=%b dat=%h, required 0 0 0",
                     ack, irq, rdat);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 5; r++) begin
            rd(32'(r * 4), q);
            checks++;
            if (q !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg%0d got %h required 00000000", r, q);
            end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] q;
        stop_timer();
        wr(PRESC, 32'd0);
        wr(LOAD, 32'd3);
        wr(COUNT, 32'd3);
        wr(CTRL, 32'h7);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL periodic_early clk%0d irq=%b required 0", k, irq);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL periodic_first irq=%b required 1", irq);
        end
        wr(STATUS, 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL periodic_cleared irq=%b required 0", irq);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL periodic_second irq=%b required 1", irq);
        end
        wr(STATUS, 32'd1);
        rd(COUNT, q);
        checks++;
        if (q !== 32'd1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL periodic_count got %h irq=%b required 00000001 irq=0", q, irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL periodic_third irq=%b required 1", irq);
        end
        stop_timer();
    endtask

    task automatic test_prescaler();
        wr(PRESC, 32'd9);
        wr(LOAD, 32'd0);
        wr(COUNT, 32'd0);
        wr(CTRL, 32'h7);
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL presc_early irq=%b required 0", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL presc_first irq=%b required 1", irq);
        end
        wr(STATUS, 32'd1);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL presc_w1c irq=%b required 0", irq);
        end
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL presc_gap irq=%b required 0", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL presc_second irq=%b required 1", irq);
        end
        wr(STATUS, 32'd1, 4'b0010);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL presc_w1c_lane irq=%b required 1", irq);
        end
        stop_timer();
    endtask

    task automatic test_oneshot();
        logic [31:0] q;
        wr(PRESC, 32'd1);
        wr(LOAD, 32'd7);
        wr(COUNT, 32'd5);
        wr(CTRL, 32'h5);
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_early irq=%b required 0", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_exp irq=%b required 1", irq);
        end
        rd(CTRL, q);
        checks++;
        if (q !== 32'h4) begin
            errors++;
            $display("FAIL oneshot_ctrl got %h required 00000004", q);
        end
        repeat (10) @(posedge clk);
        rd(COUNT, q);
        checks++;
        if (q !== 32'd0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_count got %h irq=%b required 00000000 irq=1", q, irq);
        end
        stop_timer();
    endtask

    task automatic test_byte_lanes();
        logic [31:0] q;
        wr(LOAD, 32'd0);
        wr(LOAD, 32'hAABBCCDD, 4'b0101);
        rd(LOAD, q);
        checks++;
        if (q !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL lanes_load got %h required 00BB00DD", q);
        end
        wr(32'h1C, 32'hFFFFFFFF);
        rd(32'h18, q);
        checks++;
        if (q !== 32'd0) begin
            errors++;
            $display("FAIL lanes_hole got %h required 00000000", q);
        end
        rd(LOAD, q);
        checks++;
        if (q !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL lanes_hole_write got %h required 00BB00DD", q);
        end
        wr(PRESC, 32'hFFFFFFFF);
        rd(PRESC, q);
        checks++;
        if (q !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL lanes_presc got %h required 0000FFFF", q);
        end
        wr(PRESC, 32'd0);
    endtask

    task automatic test_collisions();
        logic [31:0] q;
        wr(PRESC, 32'd0);
        wr(LOAD, 32'd3);
        wr(COUNT, 32'd3);
        wr(CTRL, 32'h7);
        repeat (3) @(posedge clk);
        wr(STATUS, 32'd1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL coll_w1c irq=%b required 1", irq);
        end
        stop_timer();
        wr(PRESC, 32'd3);
        wr(LOAD, 32'd200);
        wr(COUNT, 32'd50);
        wr(CTRL, 32'h3);
        repeat (3) @(posedge clk);
        wr(COUNT, 32'd100);
        rd(COUNT, q);
        checks++;
        if (q !== 32'd100) begin
            errors++;
            $display("FAIL coll_count got %0d required 100", q);
        end
        rd(COUNT, q);
        checks++;
        if (q !== 32'd100) begin
            errors++;
            $display("FAIL coll_no_early_tick got %0d required 100", q);
        end
        rd(COUNT, q);
        checks++;
        if (q !== 32'd99) begin
            errors++;
            $display("FAIL coll_next_tick got %0d required 99", q);
        end
        stop_timer();
    endtask

    task automatic test_async_reset();
        logic [31:0] q;
        wr(PRESC, 32'd0);
        wr(LOAD, 32'd3);
        wr(COUNT, 32'd3);
        wr(CTRL, 32'h7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        adr = LOAD; we = 1'b0; sel = 4'h0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre ack=%b irq=%b required 1 1", ack, irq);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || irq !== 1'b0 || rdat !== 32'd0) begin
            errors++;
            $display("FAIL areset_now ack=%b irq=%b dat=%h required 0 0 0",
                     ack, irq, rdat);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 5; r++) begin
            rd(32'(r * 4), q);
            checks++;
            if (q !== 32'd0) begin
                errors++;
                $display("FAIL areset_reg%0d got %h required 00000000", r, q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_prescaler();
        test_oneshot();
        test_byte_lanes();
        test_collisions();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
